gon_gather: RTL and testbench
=============================

# gon_gather

Global output network (GON) for the PE array: the return path of the global input network. It gathers partial sums from the NUMS_PE_ROW × NUMS_PE_COL PE array back toward the output SRAM. Per-PE XID and per-row YID registers are loaded by scan chains. The controller drives tag_X/tag_Y to select one PE per transfer. Accepted words are held in a 2-entry output FIFO, which decouples PE handshakes from the SRAM-side handshake.

## Interface
- NUMS_PE_ROW, 6, PE rows
- NUMS_PE_COL, 8, PEs per row
- DATA_BITS, 32, word width
- XID_BITS, 5, X tag / ID width
- YID_BITS, 4, Y tag / ID width
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- tag_X  in  XID_BITS  X tag of the PE to read
- tag_Y  in  YID_BITS  Y tag of the PE to read
- set_XID  in  1  shift XID chain one position this cycle
- XID_scan_in  in  XID_BITS  XID chain input
- set_YID  in  1  shift YID chain one position this cycle
- YID_scan_in  in  YID_BITS  YID chain input
- PE_valid  in  ROW*COL  per-PE word available; PE k = row*COL+col
- PE_ready  out  ROW*COL  per-PE accept
- PE_data  in  ROW*COL*DATA_BITS  packed PE words; PE k at [DATA_BITS*k +: DATA_BITS]
- GON_valid  out  1  word available to SRAM
- GON_ready  in  1  SRAM accepts
- GON_data  out  DATA_BITS  FIFO head word

## Operation
- ID chains:
  - set_YID=1: YID[0]<=YID_scan_in, YID[r]<=YID[r-1].
  - set_XID=1: XID[0]<=XID_scan_in, XID[k]<=XID[k-1] over all ROW*COL PEs, row-major.
  - Both chains may shift in the same cycle. All IDs reset to 0.
- Match: match[k] = (YID[k/COL]==tag_Y) && (XID[k]==tag_X).
- Unicast select: only the lowest-index matching PE is selected (one-hot sel). No match means no selection.
- PE_ready[k] = sel[k] && !full && !set_XID && !set_YID, where full = (count==2). All other PE_ready bits are 0.
- Push when PE_valid[k] && PE_ready[k]: PE_data word k is written at the FIFO tail.
- Pop when GON_valid && GON_ready; the head advances.
- FIFO: 2 entries, count 0..2, write/read pointers 1 bit each, wrapping 1→0.
  - GON_valid = (count!=0).
  - GON_data = head entry, registered storage and not a combinational path from PE_data.
- Simultaneous push and pop at count 1: count stays 1 and both pointers advance.
- At count 2, PE_ready is 0 even if pop occurs that cycle; there is no ready-to-ready combinational path.
- Tag changes affect only future selection. Buffered words are unaffected.
- A PE_valid bit on a non-selected PE is ignored and never drops data.

## Timing
- Reset values: PE_ready=0, GON_valid=0, GON_data=0, count=0, pointers=0, all XID/YID=0.
- Reset mid-transfer discards buffered words immediately (asynchronous).
- Latency: a word pushed at edge t has GON_valid=1 and GON_data equal to that word after edge t.
- Throughput: 1 word/cycle sustained when GON_ready is held 1.
- PE_ready is combinational from tags, IDs, count and set_*. PE_valid does not feed PE_ready.
- GON_valid and GON_data depend on flops only.
- ID shift takes effect after the edge. Matching in the next cycle uses the new IDs.
- While set_XID or set_YID is high, no push occurs. Pops continue.

## Test plan
- Reset/config: hold rst=0 → all outputs 0. Scan 6 YIDs {5,4,3,2,1,0} with 6 set_YID cycles → YID[r]=r. Scan 48 XIDs so XID[k]=k%8.
- Unicast: tag_Y=2, tag_X=3, PE_valid[19]=1, PE_data[19]=0xDEADBEEF, GON_ready=1 → PE_ready=only bit 19. GON_valid=1 with GON_data=0xDEADBEEF one cycle later.
- Backpressure: GON_ready=0 with 3 words offered from PE 19 → 2 accepted, then PE_ready[19]=0. Raise GON_ready → words drain in order, then the third word is accepted.
- Priority/no-match: set all XIDs=0 and tag_X=0, tag_Y=1 → only PE 8 is ready. tag_Y=15 → no PE_ready bit set, FIFO unchanged.
- Config gating: set_XID=1 while PE 19 is valid and selected → PE_ready=0, no push. A buffered word still pops.
- Reset mid-op: FIFO holds 2 words, assert rst → GON_valid=0 immediately. After release, count=0 and IDs=0.

Source files
------------

// File: rtl/gon_gather_if.sv
// gon_gather_if: PE-side and SRAM-side handshake bundle plus tag/scan controls for gon_gather.
interface gon_gather_if #(
  parameter int NUMS_PE_ROW = 6,
  parameter int NUMS_PE_COL = 8,
  parameter int DATA_BITS   = 32,
  parameter int XID_BITS    = 5,
  parameter int YID_BITS    = 4
);
  logic [XID_BITS-1:0]                        tag_X;
  logic [YID_BITS-1:0]                        tag_Y;
  logic                                       set_XID;
  logic [XID_BITS-1:0]                        XID_scan_in;
  logic                                       set_YID;
  logic [YID_BITS-1:0]                        YID_scan_in;
  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]         PE_valid;
  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]         PE_ready;
  logic [NUMS_PE_ROW*NUMS_PE_COL*DATA_BITS-1:0] PE_data;
  logic                                       GON_valid;
  logic                                       GON_ready;
  logic [DATA_BITS-1:0]                       GON_data;
  modport master (
    output tag_X, tag_Y, set_XID, XID_scan_in, set_YID, YID_scan_in, PE_valid, PE_data, GON_ready,
    input  PE_ready, GON_valid, GON_data
  );
  modport slave (
    input  tag_X, tag_Y, set_XID, XID_scan_in, set_YID, YID_scan_in, PE_valid, PE_data, GON_ready,
    output PE_ready, GON_valid, GON_data
  );
endinterface

// File: rtl/gon_gather.sv
// gon_gather: tag-matched unicast gather from the PE array into a 2-entry output FIFO.
module gon_gather #(
  parameter int NUMS_PE_ROW = 6,
  parameter int NUMS_PE_COL = 8,
  parameter int DATA_BITS   = 32,
  parameter int XID_BITS    = 5,
  parameter int YID_BITS    = 4
) (
  input logic         clk,
  input logic         rst,
  gon_gather_if.slave bus
);
  localparam int N = NUMS_PE_ROW * NUMS_PE_COL;
  logic [XID_BITS-1:0]  xid [N];
  logic [YID_BITS-1:0]  yid [NUMS_PE_ROW];
  logic [N-1:0]         match, sel;
  logic [DATA_BITS-1:0] mem [2];
  logic [DATA_BITS-1:0] push_data;
  logic [1:0]           count;
  logic                 wp, rp, full, cfg, push, pop;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int r = 0; r < NUMS_PE_ROW; r++) yid[r] <= '0;
      for (int k = 0; k < N; k++) xid[k] <= '0;
    end else begin
      if (bus.set_YID) begin
        yid[0] <= bus.YID_scan_in;
        for (int r = 1; r < NUMS_PE_ROW; r++) yid[r] <= yid[r-1];
      end
      if (bus.set_XID) begin
        xid[0] <= bus.XID_scan_in;
        for (int k = 1; k < N; k++) xid[k] <= xid[k-1];
      end
    end
  for (genvar k = 0; k < N; k++) begin : g_match
    assign match[k] = (yid[k/NUMS_PE_COL] == bus.tag_Y) && (xid[k] == bus.tag_X);
  end
  // Two's-complement trick isolates the lowest set bit, giving the one-hot unicast select.
  assign sel  = match & (~match + N'(1));
  assign full = count == 2'd2;
  assign cfg  = bus.set_XID | bus.set_YID;
  always_comb begin
    bus.PE_ready = rst ? sel & {N{~full & ~cfg}} : '0;
    push_data = '0;
    for (int k = 0; k < N; k++) push_data = push_data | (sel[k] ? bus.PE_data[k*DATA_BITS +: DATA_BITS] : '0);
  end
  assign push          = |(bus.PE_valid & bus.PE_ready);
  assign pop           = bus.GON_valid & bus.GON_ready;
  assign bus.GON_valid = count != 2'd0;
  assign bus.GON_data  = mem[rp];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      count  <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= push_data;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
endmodule

// File: tb/tb_gon_gather.sv
// tb_gon_gather: directed checks of ID scan, unicast select, FIFO backpressure, config gating and reset.
module tb_gon_gather;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  gon_gather_if #(.NUMS_PE_ROW(6), .NUMS_PE_COL(8), .DATA_BITS(32), .XID_BITS(5), .YID_BITS(4)) bus ();
  gon_gather #(.NUMS_PE_ROW(6), .NUMS_PE_COL(8), .DATA_BITS(32), .XID_BITS(5), .YID_BITS(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    bus.tag_X = '0; bus.tag_Y = '0; bus.set_XID = 1'b0; bus.XID_scan_in = '0;
    bus.set_YID = 1'b0; bus.YID_scan_in = '0; bus.PE_valid = '0; bus.PE_data = '0; bus.GON_ready = 1'b0;
  endtask
  task automatic test_reset;
    idle();
    rst = 1'b0;
    tick();
    checks++; if (bus.PE_ready !== 48'd0) begin errors++; $display("FAIL reset_pe_ready got %h exp 0", bus.PE_ready); end
    checks++; if (bus.GON_valid !== 1'b0) begin errors++; $display("FAIL reset_gon_valid got %b exp 0", bus.GON_valid); end
    checks++; if (bus.GON_data !== 32'd0) begin errors++; $display("FAIL reset_gon_data got %h exp 0", bus.GON_data); end
    #2 rst = 1'b1;
    tick();
    checks++; if (bus.PE_ready !== 48'd1) begin errors++; $display("FAIL reset_ids_zero_sel got %h exp 1", bus.PE_ready); end
  endtask
  task automatic test_config;
    bus.tag_Y = 4'd15;
    for (int s = 0; s < 48; s++) begin
      bus.set_XID = 1'b1;
      bus.XID_scan_in = 5'((47 - s) % 8);
      bus.set_YID = s < 6;
      bus.YID_scan_in = 4'((5 - s) & 7);
      tick();
    end
    bus.set_XID = 1'b0; bus.set_YID = 1'b0;
    bus.tag_Y = 4'd5; bus.tag_X = 5'd7;
    #1;
    checks++; if (bus.PE_ready !== (48'd1 << 47)) begin errors++; $display("FAIL config_pe47 got %h exp %h", bus.PE_ready, 48'd1 << 47); end
    bus.tag_Y = 4'd0; bus.tag_X = 5'd0;
    #1;
    checks++; if (bus.PE_ready !== 48'd1) begin errors++; $display("FAIL config_pe0 got %h exp 1", bus.PE_ready); end
  endtask
  task automatic test_unicast;
    bus.tag_Y = 4'd2; bus.tag_X = 5'd3; bus.GON_ready = 1'b1;
    bus.PE_valid = 48'd1 << 19;
    bus.PE_data[19*32 +: 32] = 32'hDEADBEEF;
    #1;
    checks++; if (bus.PE_ready !== (48'd1 << 19)) begin errors++; $display("FAIL unicast_ready got %h exp %h", bus.PE_ready, 48'd1 << 19); end
    tick();
    bus.PE_valid = '0;
    checks++; if (bus.GON_valid !== 1'b1) begin errors++; $display("FAIL unicast_valid got %b exp 1", bus.GON_valid); end
    checks++; if (bus.GON_data !== 32'hDEADBEEF) begin errors++; $display("FAIL unicast_data got %h exp deadbeef", bus.GON_data); end
    tick();
    checks++; if (bus.GON_valid !== 1'b0) begin errors++; $display("FAIL unicast_drain got %b exp 0", bus.GON_valid); end
  endtask
  task automatic test_backpressure;
    logic [31:0] w [3];
    w[0] = 32'h1111_0001; w[1] = 32'h2222_0002; w[2] = 32'h3333_0003;
    bus.tag_Y = 4'd2; bus.tag_X = 5'd3; bus.GON_ready = 1'b0;
    bus.PE_valid = 48'd1 << 19;
    for (int i = 0; i < 2; i++) begin
      bus.PE_data[19*32 +: 32] = w[i];
      #1;
      checks++; if (bus.PE_ready !== (48'd1 << 19)) begin errors++; $display("FAIL bp_accept%0d got %h exp %h", i, bus.PE_ready, 48'd1 << 19); end
      tick();
    end
    bus.PE_data[19*32 +: 32] = w[2];
    #1;
    checks++; if (bus.PE_ready !== 48'd0) begin errors++; $display("FAIL bp_full_ready got %h exp 0", bus.PE_ready); end
    checks++; if (bus.GON_data !== w[0]) begin errors++; $display("FAIL bp_head0 got %h exp %h", bus.GON_data, w[0]); end
    tick();
    checks++; if (bus.GON_data !== w[0]) begin errors++; $display("FAIL bp_hold got %h exp %h", bus.GON_data, w[0]); end
    bus.GON_ready = 1'b1;
    #1;
    checks++; if (bus.PE_ready !== 48'd0) begin errors++; $display("FAIL bp_full_pop_ready got %h exp 0", bus.PE_ready); end
    tick();
    checks++; if (bus.GON_data !== w[1]) begin errors++; $display("FAIL bp_head1 got %h exp %h", bus.GON_data, w[1]); end
    checks++; if (bus.PE_ready !== (48'd1 << 19)) begin errors++; $display("FAIL bp_ready_again got %h exp %h", bus.PE_ready, 48'd1 << 19); end
    tick();
    bus.PE_valid = '0;
    checks++; if (bus.GON_valid !== 1'b1 || bus.GON_data !== w[2]) begin errors++; $display("FAIL bp_head2 got %b/%h exp 1/%h", bus.GON_valid, bus.GON_data, w[2]); end
    tick();
    checks++; if (bus.GON_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", bus.GON_valid); end
  endtask
  task automatic test_priority;
    bus.GON_ready = 1'b0;
    for (int s = 0; s < 48; s++) begin
      bus.set_XID = 1'b1; bus.XID_scan_in = '0;
      tick();
    end
    bus.set_XID = 1'b0;
    for (int k = 0; k < 48; k++) bus.PE_data[k*32 +: 32] = 32'hA500_0000 | 32'(k);
    bus.tag_X = 5'd0; bus.tag_Y = 4'd1;
    #1;
    checks++; if (bus.PE_ready !== (48'd1 << 8)) begin errors++; $display("FAIL prio_pe8 got %h exp %h", bus.PE_ready, 48'd1 << 8); end
    bus.tag_Y = 4'd15; bus.PE_valid = '1;
    #1;
    checks++; if (bus.PE_ready !== 48'd0) begin errors++; $display("FAIL nomatch_ready got %h exp 0", bus.PE_ready); end
    tick();
    checks++; if (bus.GON_valid !== 1'b0) begin errors++; $display("FAIL nomatch_fifo got %b exp 0", bus.GON_valid); end
    bus.tag_Y = 4'd1;
    tick();
    bus.PE_valid = '0;
    checks++; if (bus.GON_data !== 32'hA500_0008) begin errors++; $display("FAIL prio_data got %h exp a5000008", bus.GON_data); end
    bus.GON_ready = 1'b1;
    tick();
    bus.GON_ready = 1'b0;
  endtask
  task automatic test_config_gating;
    bus.tag_X = 5'd0; bus.tag_Y = 4'd1; bus.GON_ready = 1'b0;
    bus.PE_valid = 48'd1 << 8;
    bus.PE_data[8*32 +: 32] = 32'hCAFE_0008;
    tick();
    bus.PE_data[8*32 +: 32] = 32'hBAD0_0008;
    bus.set_YID = 1'b1;
    #1;
    checks++; if (bus.PE_ready !== 48'd0) begin errors++; $display("FAIL gate_yid_ready got %h exp 0", bus.PE_ready); end
    bus.set_YID = 1'b0; bus.set_XID = 1'b1; bus.XID_scan_in = '0; bus.GON_ready = 1'b1;
    #1;
    checks++; if (bus.PE_ready !== 48'd0) begin errors++; $display("FAIL gate_xid_ready got %h exp 0", bus.PE_ready); end
    checks++; if (bus.GON_data !== 32'hCAFE_0008) begin errors++; $display("FAIL gate_head got %h exp cafe0008", bus.GON_data); end
    tick();
    bus.set_XID = 1'b0; bus.PE_valid = '0;
    checks++; if (bus.GON_valid !== 1'b0) begin errors++; $display("FAIL gate_no_push got %b exp 0", bus.GON_valid); end
  endtask
  task automatic test_reset_midop;
    bus.tag_X = 5'd0; bus.tag_Y = 4'd1; bus.GON_ready = 1'b0;
    bus.PE_valid = 48'd1 << 8;
    tick();
    tick();
    bus.PE_valid = '0;
    checks++; if (bus.GON_valid !== 1'b1 || bus.PE_ready !== 48'd0) begin errors++; $display("FAIL midop_full got %b/%h exp 1/0", bus.GON_valid, bus.PE_ready); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.GON_valid !== 1'b0) begin errors++; $display("FAIL midop_valid got %b exp 0", bus.GON_valid); end
    checks++; if (bus.GON_data !== 32'd0) begin errors++; $display("FAIL midop_data got %h exp 0", bus.GON_data); end
    #2 rst = 1'b1;
    tick();
    checks++; if (bus.PE_ready !== 48'd0) begin errors++; $display("FAIL midop_yid_cleared got %h exp 0", bus.PE_ready); end
    bus.tag_Y = 4'd0;
    #1;
    checks++; if (bus.PE_ready !== 48'd1) begin errors++; $display("FAIL midop_ids_zero got %h exp 1", bus.PE_ready); end
    tick();
    checks++; if (bus.GON_valid !== 1'b0) begin errors++; $display("FAIL midop_count0 got %b exp 0", bus.GON_valid); end
  endtask
  initial begin
    test_reset();
    test_config();
    test_unicast();
    test_backpressure();
    test_priority();
    test_config_gating();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
